uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO draining into an LSB-first RS-232 serializer (8N1 by default).
// Define UART_TX_PARITY_EN to add an even-parity bit after the data (8E1 frames).
module uart_tx_fifo #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 16,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level,
  output logic        tx_busy,
  output logic        rs232_tx
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int CW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3
  } state_t;
`endif

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q, level_d;
  logic          full_q, empty_q;
  logic          push_s, pop_s;

  state_t        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q, busy_q, line_s, baud_last_s;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  assign push_s      = wr_en && !full_q;
  assign pop_s       = (state_q == S_IDLE) && !empty_q;
  assign baud_last_s = (baud_q == BAUD_LAST);

  // Occupancy next-state from the accepted push / pop pair.
  always_comb begin
    level_d = level_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Buffer storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  // Pointers and flags; full/empty are derived from the same next level.
  always_ff @(posedge clk) begin
    if (nreset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_s) wptr_q <= wptr_q + PTR_ONE;
      if (pop_s)  rptr_q <= rptr_q + PTR_ONE;
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
      empty_q <= (level_d == '0);
    end
  end

  // Line value for the current state; registered below, so the pin lags state by one clock.
  always_comb begin
    line_s = 1'b1;
    case (state_q)
      S_IDLE:   line_s = 1'b1;
      S_START:  line_s = 1'b0;
      S_DATA:   line_s = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_s = par_q;
`endif
      S_STOP:   line_s = 1'b1;
      default:  line_s = 1'b1;
    endcase
  end

  // Serializer FSM with registered line and busy outputs.
  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      tx_q <= line_s;
      case (state_q)
        S_IDLE: begin
          if (pop_s) begin
            shift_q <= mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
            par_q   <= even_parity(mem_q[rptr_q]);
`endif
            baud_q  <= '0;
            bit_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_last_s) begin
            baud_q  <= '0;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (baud_last_s) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_last_s) begin
            baud_q  <= '0;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
`endif
        S_STOP: begin
          if (baud_last_s) begin
            baud_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        default: begin
          baud_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign tx_busy  = busy_q;
  assign rs232_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: per-cycle model compare, UART receiver, directed scenarios.
module tb_uart_tx_fifo;
  localparam int CLK_FREQ = 100;
  localparam int BAUD     = 10;
  localparam int DEPTH    = 4;
  localparam int BC       = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BC;

  logic       clk     = 1'b0;
  logic       nreset  = 1'b1;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, tx_busy, rs232_tx;
  logic [2:0] level;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk), .nreset(nreset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .tx_busy(tx_busy), .rs232_tx(rs232_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte queue plus "which frame, how far in"; the line shows the frame bit one clock late.
  logic [7:0] m_q[$];
  bit         m_busy  = 1'b0;
  int         m_k     = 0;
  logic [7:0] m_byte  = 8'h00;
  logic       m_tx    = 1'b1;
  bit         m_valid = 1'b0;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  initial begin : model
    bit can_push, pop;
    forever begin
      @(posedge clk);
      if (nreset) begin
        m_q.delete();
        m_busy  = 1'b0;
        m_k     = 0;
        m_tx    = 1'b1;
        m_valid = 1'b1;
      end else begin
        can_push = wr_en && (m_q.size() < DEPTH);
        pop      = !m_busy && (m_q.size() > 0);
        m_tx     = m_busy ? frame_bit(m_byte, m_k / BC) : 1'b1;
        if (m_busy) begin
          m_k++;
          if (m_k == FRAME) m_busy = 1'b0;
        end
        if (pop) begin
          m_byte = m_q.pop_front();
          m_busy = 1'b1;
          m_k    = 0;
        end
        if (can_push) m_q.push_back(wr_data);
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("level",    32'(level),    32'(m_q.size()));
        chk("empty",    32'(empty),    32'(m_q.size() == 0));
        chk("full",     32'(full),     32'(m_q.size() == DEPTH));
        chk("tx_busy",  32'(tx_busy),  32'(m_busy));
        chk("rs232_tx", 32'(rs232_tx), 32'(m_tx));
      end
    end
  end

  // Receiver: mid-bit sampling after each falling start edge.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit         mon_quiet = 1'b0;

  initial begin : monitor
    logic       prev, sb;
    logic [7:0] b;
`ifdef UART_TX_PARITY_EN
    logic       pb;
`endif
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && rs232_tx === 1'b0) begin
        repeat (BC/2) @(negedge clk);
        sb = rs232_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BC) @(negedge clk);
          b[i] = rs232_tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (BC) @(negedge clk);
        pb = rs232_tx;
`endif
        repeat (BC) @(negedge clk);
        if (!mon_quiet) begin
          chk("rx_start", 32'(sb), 32'd0);
`ifdef UART_TX_PARITY_EN
          chk("rx_parity", 32'(pb), 32'(^b));
`endif
          chk("rx_stop", 32'(rs232_tx), 32'd1);
          rx_q.push_back(b);
        end
      end
      prev = rs232_tx;
    end
  end

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    wr_en  = 1'b0;
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    nreset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cnt;
    cnt = 0;
    while (!(tx_busy === 1'b0 && empty === 1'b1) && cnt < 20*FRAME) begin
      @(negedge clk);
      cnt++;
    end
    chk(name, 32'(cnt < 20*FRAME), 32'd1);
    idle(5);
  endtask

  task automatic chk_rx(input string name);
    chk({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk(name, 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic tx_hist[130];
    logic busy_hist[130];
    logic empty_hist[130];
    logic bh[620];
    int   lv[620];
    logic fl[620];
    int   first_low, busy_cnt, cnt, lows, busy_seen, max_lvl, first_b, last_b, gaps;
    int   exp_lvl[6] = '{1, 1, 2, 3, 4, 4};
    logic exp_full[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef UART_TX_PARITY_EN
    logic a5_bits[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    logic a5_bits[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

    do_reset();
    chk("rst_tx",    32'(rs232_tx), 32'd1);
    chk("rst_busy",  32'(tx_busy),  32'd0);
    chk("rst_empty", 32'(empty),    32'd1);
    chk("rst_full",  32'(full),     32'd0);
    chk("rst_level", 32'(level),    32'd0);

    // Single byte 0xA5
    idle(3);
    wr(8'hA5);
    for (int j = 0; j < 130; j++) begin
      tx_hist[j] = rs232_tx; busy_hist[j] = tx_busy; empty_hist[j] = empty;
      @(negedge clk);
    end
    first_low = -1;
    busy_cnt  = 0;
    for (int j = 0; j < 130; j++) begin
      if (first_low < 0 && tx_hist[j] === 1'b0) first_low = j;
      if (busy_hist[j] === 1'b1) busy_cnt++;
    end
    chk("t1_start_latency", 32'(first_low), 32'd2);
    chk("t1_busy_clocks",   32'(busy_cnt),  32'(FRAME));
    chk("t1_empty_written", 32'(empty_hist[0]), 32'd0);
    chk("t1_empty_popped",  32'(empty_hist[1]), 32'd1);
    chk("t1_idle_before",   32'(tx_hist[1]),    32'd1);
    for (int i = 0; i < NBITS; i++)
      chk("t1_bit", 32'(tx_hist[2 + BC*i + BC/2]), 32'(a5_bits[i]));
    chk("t1_idle_after", 32'(tx_hist[2 + FRAME]), 32'd1);
    wait_drain("t1_drain");
    exp_q.push_back(8'hA5);
    chk_rx("t1_rx");

    // Burst of six into a four-deep FIFO
    fork
      begin
        for (int k = 0; k < 6; k++) wr(8'(k + 1));
      end
      begin
        for (int j = 0; j < 620; j++) begin
          bh[j] = tx_busy; lv[j] = int'(level); fl[j] = full;
          @(negedge clk);
        end
      end
    join
    for (int k = 0; k < 6; k++) begin
      chk("t2_level", 32'(lv[k+1]), 32'(exp_lvl[k]));
      chk("t2_full",  32'(fl[k+1]), 32'(exp_full[k]));
    end
    first_b = -1; last_b = -1; busy_cnt = 0; gaps = 0;
    for (int j = 0; j < 620; j++) begin
      if (bh[j] === 1'b1) begin
        if (first_b < 0) first_b = j;
        last_b = j;
        busy_cnt++;
      end
    end
    for (int j = 0; j < 620; j++)
      if (first_b >= 0 && j > first_b && j < last_b && bh[j] !== 1'b1) gaps++;
    chk("t2_busy_clocks", 32'(busy_cnt), 32'(5*FRAME));
    chk("t2_gap_clocks",  32'(gaps),     32'd4);
    wait_drain("t2_drain");
    for (int k = 1; k <= 5; k++) exp_q.push_back(8'(k));
    chk_rx("t2_rx");

    // Push in the same cycle as a pop
    wr(8'h3C);
    idle(5);
    wr(8'h5A);
    chk("t3_level_queued", 32'(level), 32'd1);
    cnt = 0;
    while (tx_busy !== 1'b0 && cnt < 2*FRAME) begin
      @(negedge clk);
      cnt++;
    end
    chk("t3_wait_idle", 32'(cnt < 2*FRAME), 32'd1);
    wr(8'h77);
    chk("t3_level_same", 32'(level),   32'd1);
    chk("t3_busy",       32'(tx_busy), 32'd1);
    wait_drain("t3_drain");
    exp_q.push_back(8'h3C); exp_q.push_back(8'h5A); exp_q.push_back(8'h77);
    chk_rx("t3_rx");

    // Reset during data bit 3 (0xC3 bit 3 = 0), second byte queued
    wr(8'hC3);
    wr(8'h99);
    idle(44);
    chk("t4_busy_before", 32'(tx_busy),  32'd1);
    chk("t4_tx_before",   32'(rs232_tx), 32'd0);
    mon_quiet = 1'b1;
    nreset = 1'b1;
    @(negedge clk);
    nreset = 1'b0;
    chk("t4_tx",    32'(rs232_tx), 32'd1);
    chk("t4_busy",  32'(tx_busy),  32'd0);
    chk("t4_level", 32'(level),    32'd0);
    chk("t4_empty", 32'(empty),    32'd1);
    lows = 0; busy_seen = 0;
    for (int j = 0; j < 300; j++) begin
      if (rs232_tx !== 1'b1) lows++;
      if (tx_busy !== 1'b0) busy_seen++;
      @(negedge clk);
    end
    chk("t4_line_quiet", 32'(lows),      32'd0);
    chk("t4_no_frames",  32'(busy_seen), 32'd0);
    mon_quiet = 1'b0;
    rx_q.delete();

    // Pointer wrap: twelve bytes with level held at or below 3
    max_lvl = 0;
    for (int k = 0; k < 12; k++) begin
      cnt = 0;
      while (level >= 3'd3 && cnt < 2*FRAME) begin
        @(negedge clk);
        cnt++;
      end
      chk("t5_wait_room", 32'(cnt < 2*FRAME), 32'd1);
      wr(8'h10 + 8'(k));
      if (int'(level) > max_lvl) max_lvl = int'(level);
      exp_q.push_back(8'h10 + 8'(k));
    end
    chk("t5_max_level", 32'(max_lvl <= 3), 32'd1);
    wait_drain("t5_drain");
    chk_rx("t5_rx");

`ifdef UART_TX_PARITY_EN
    // Parity of 0x07 (three ones) is 1
    do_reset();
    idle(3);
    wr(8'h07);
    for (int j = 0; j < 130; j++) begin
      tx_hist[j] = rs232_tx; busy_hist[j] = tx_busy;
      @(negedge clk);
    end
    busy_cnt = 0;
    for (int j = 0; j < 130; j++) if (busy_hist[j] === 1'b1) busy_cnt++;
    chk("t6_parity_bit", 32'(tx_hist[2 + BC*9 + BC/2]), 32'd1);
    chk("t6_busy_clocks", 32'(busy_cnt), 32'd110);
    wait_drain("t6_drain");
    exp_q.push_back(8'h07);
    chk_rx("t6_rx");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
